// File: rtl/ppu_pkg.sv
// Shared PPU definitions: CPU register indices, palette address window and
// the VRAM access port FSM state encoding.
// Pure declarations, no logic.
package ppu_pkg;

    // CPU register index ($2000 + n)
    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    // Addresses at or above this are served by palette RAM, not the mapper
    localparam logic [13:0] PALETTE_BASE = 14'h3F00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ADDR,
        ST_RD_LATCH
    } vram_state_t;

    function automatic logic is_palette(input logic [13:0] addr);
        return addr >= PALETTE_BASE;
    endfunction

endpackage

// File: rtl/ppu_vram_port.sv
// CPU-side VRAM access port: PPUCTRL/PPUSTATUS/PPUADDR/PPUDATA decode, v/t/w, read buffer, palette bypass.
// Latency: register effects T+1; PPUDATA write strobes in T+1; PPUDATA read data T+1, buffer refill done at T+3.
// Backpressure: none on the CPU side; a cpu_cs arriving while busy is dropped without any state change.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   cpu_cs/rw/reg/din   - one-cycle CPU register strobe, direction, index, write data
//   cpu_dout, busy      - registered PPUDATA read result, access FSM not idle
//   vram_addr/we/wdata  - address, write strobe and data to the VRAM mapper
//   vram_rdata          - mapper read data, one cycle after vram_addr
//   pal_addr/we/rdata   - palette RAM address (v[4:0]), write strobe, combinational read data
module ppu_vram_port
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cs,
    input  logic        cpu_rw,
    input  logic [2:0]  cpu_reg,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        busy,
    output logic [15:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic [4:0]  pal_addr,
    output logic        pal_we,
    input  logic [7:0]  pal_rdata
);

    vram_state_t state;
    logic [13:0] v;
    // Only the high half of t is ever read back: the low byte written by the
    // second PPUADDR write goes straight into v in the same cycle, so it is
    // not kept as separate state here.
    logic [13:8] t_hi;
    logic        w;
    logic        inc32;
    logic [7:0]  rbuf;

    logic [13:0] v_next;
    logic        v_pal;
    logic [13:0] fill_addr;

    assign v_next   = v + (inc32 ? 14'd32 : 14'd1);
    assign v_pal    = is_palette(v);
    assign busy     = (state != ST_IDLE);
    assign pal_addr = v[4:0];

    // A palette read refills the buffer from the nametable mirrored underneath
    // the palette window, i.e. with address bit 12 cleared.
    always_comb begin
        fill_addr = v;
        if ((state == ST_RD_ADDR || state == ST_RD_LATCH) && v_pal) begin
            fill_addr = v & ~14'h1000;
        end
        vram_addr = {2'b00, fill_addr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            v          <= '0;
            t_hi       <= '0;
            w          <= 1'b0;
            inc32      <= 1'b0;
            rbuf       <= '0;
            cpu_dout   <= '0;
            vram_wdata <= '0;
            vram_we    <= 1'b0;
            pal_we     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_cs) begin
                        case (cpu_reg)
                            PPUCTRL: begin
                                if (!cpu_rw) inc32 <= cpu_din[2];
                            end
                            PPUSTATUS: begin
                                if (cpu_rw) w <= 1'b0;
                            end
                            PPUADDR: begin
                                if (!cpu_rw) begin
                                    if (!w) begin
                                        t_hi <= cpu_din[5:0];
                                        w    <= 1'b1;
                                    end else begin
                                        v <= {t_hi, cpu_din};
                                        w <= 1'b0;
                                    end
                                end
                            end
                            PPUDATA: begin
                                if (!cpu_rw) begin
                                    vram_wdata <= cpu_din;
                                    if (v_pal) pal_we  <= 1'b1;
                                    else       vram_we <= 1'b1;
                                    state <= ST_WR;
                                end else begin
                                    // Palette reads bypass the buffer; others return the stale buffer
                                    cpu_dout <= v_pal ? pal_rdata : rbuf;
                                    state    <= ST_RD_ADDR;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WR: begin
                    vram_we <= 1'b0;
                    pal_we  <= 1'b0;
                    v       <= v_next;
                    state   <= ST_IDLE;
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_LATCH;
                end
                ST_RD_LATCH: begin
                    rbuf  <= vram_rdata;
                    v     <= v_next;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_vram_port.sv
module tb_ppu_vram_port;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_cs;
    logic        cpu_rw;
    logic [2:0]  cpu_reg;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        busy;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [4:0]  pal_addr;
    logic        pal_we;
    logic [7:0]  pal_rdata;

    ppu_vram_port dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_cs     (cpu_cs),
        .cpu_rw     (cpu_rw),
        .cpu_reg    (cpu_reg),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .busy       (busy),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .pal_addr   (pal_addr),
        .pal_we     (pal_we),
        .pal_rdata  (pal_rdata)
    );

    always #5 clk = ~clk;

    // Read-only mapper and palette contents owned by the bench
    logic [7:0] mem     [0:16383];
    logic [7:0] pal_mem [0:31];

    always @(posedge clk) vram_rdata <= mem[vram_addr[13:0]];
    assign pal_rdata = pal_mem[pal_addr];

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        pal;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [7:0] rd_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [13:0] v_m;
    logic [13:8] t_m;
    logic        w_m;
    logic        inc32_m;
    logic [7:0]  rbuf_m;
    logic [7:0]  dout_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write-side scoreboard: every strobe seen must match the oldest expected write
    always @(negedge clk) begin
        if (vram_we || pal_we) begin
            check("we_expected", {31'd0, wr_q.size() > 0}, 32'd1);
            if (wr_q.size() > 0) begin
                wr_exp_t e;
                e = wr_q.pop_front();
                check("we_addr", {16'd0, vram_addr}, {16'd0, e.addr});
                check("we_data", {24'd0, vram_wdata}, {24'd0, e.data});
                check("we_pal", {31'd0, pal_we}, {31'd0, e.pal});
                check("we_vram", {31'd0, vram_we}, {31'd0, !e.pal});
            end
        end
    end

    function automatic logic [13:0] inc_v(input logic [13:0] v);
        return v + (inc32_m ? 14'd32 : 14'd1);
    endfunction

    task automatic model_reset();
        v_m = '0; t_m = '0; w_m = 1'b0; inc32_m = 1'b0; rbuf_m = '0; dout_m = '0;
    endtask

    task automatic strobe(input logic rw, input logic [2:0] r, input logic [7:0] d);
        cpu_cs  = 1'b1;
        cpu_rw  = rw;
        cpu_reg = r;
        cpu_din = d;
        @(posedge clk);
        #1;
        cpu_cs  = 1'b0;
        cpu_rw  = 1'b1;
        cpu_din = 8'h00;
    endtask

    task automatic wait_idle();
        int b = 0;
        while (busy && b < 20) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_v(input string tag);
        check(tag, {16'd0, vram_addr}, {18'd0, v_m});
    endtask

    task automatic wr(input logic [2:0] r, input logic [7:0] d);
        case (r)
            PPUCTRL: inc32_m = d[2];
            PPUADDR: begin
                if (!w_m) begin
                    t_m = d[5:0];
                    w_m = 1'b1;
                end else begin
                    v_m = {t_m, d};
                    w_m = 1'b0;
                end
            end
            PPUDATA: begin
                wr_q.push_back('{addr: {2'b00, v_m}, data: d, pal: (v_m >= 14'h3F00)});
                v_m = inc_v(v_m);
            end
            default: ;
        endcase
        strobe(1'b0, r, d);
        if (r == PPUDATA) check("wr_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        check_v("v_after_wr");
    endtask

    task automatic rd(input logic [2:0] r);
        logic        pal;
        logic [13:0] fill;
        logic [7:0]  exp;
        if (r == PPUDATA) begin
            pal  = (v_m >= 14'h3F00);
            fill = pal ? (v_m & 14'h2FFF) : v_m;
            rd_q.push_back(pal ? pal_mem[v_m[4:0]] : rbuf_m);
            rbuf_m = mem[fill];
            v_m    = inc_v(v_m);
            strobe(1'b1, r, 8'h00);
            exp    = rd_q.pop_front();
            dout_m = exp;
            check("rd_dout", {24'd0, cpu_dout}, {24'd0, exp});
            check("rd_busy", {31'd0, busy}, 32'd1);
            check("rd_addr1", {16'd0, vram_addr}, {18'd0, fill});
            @(posedge clk);
            #1;
            check("rd_addr2", {16'd0, vram_addr}, {18'd0, fill});
        end else begin
            if (r == PPUSTATUS) w_m = 1'b0;
            strobe(1'b1, r, 8'h00);
            check("dout_hold", {24'd0, cpu_dout}, {24'd0, dout_m});
        end
        wait_idle();
        check_v("v_after_rd");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        cpu_cs  = 1'b0;
        cpu_rw  = 1'b1;
        cpu_reg = 3'd0;
        cpu_din = 8'h00;
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
        mem[14'h0010] = 8'h5A;
        mem[14'h0011] = 8'h77;
        for (int i = 0; i < 32; i++) pal_mem[i] = 8'(8'h40 + i);
        pal_mem[1] = 8'h1C;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_dout", {24'd0, cpu_dout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_vram_we", {31'd0, vram_we}, 32'd0);
        check("rst_pal_we", {31'd0, pal_we}, 32'd0);
        check("rst_addr", {16'd0, vram_addr}, 32'd0);
        check("rst_wdata", {24'd0, vram_wdata}, 32'd0);

        // Address load and a plain write
        wr(PPUADDR, 8'h21);
        wr(PPUADDR, 8'h08);
        check("v_2108", {16'd0, vram_addr}, 32'h2108);
        wr(PPUDATA, 8'hAB);
        check("v_2109", {16'd0, vram_addr}, 32'h2109);

        // Increment by 32
        wr(PPUCTRL, 8'h04);
        wr(PPUADDR, 8'h20);
        wr(PPUADDR, 8'h00);
        wr(PPUDATA, 8'h11);
        wr(PPUDATA, 8'h22);
        wr(PPUDATA, 8'h33);
        wr(PPUCTRL, 8'h00);

        // Buffered reads: stale buffer first
        wr(PPUADDR, 8'h00);
        wr(PPUADDR, 8'h10);
        rd(PPUDATA);
        rd(PPUDATA);
        check("v_0012", {16'd0, vram_addr}, 32'h0012);

        // Palette read bypass and nametable refill, then palette write
        wr(PPUADDR, 8'h3F);
        wr(PPUADDR, 8'h01);
        rd(PPUDATA);
        wr(PPUDATA, 8'h55);
        wr(PPUADDR, 8'h00);
        wr(PPUADDR, 8'h40);
        rd(PPUDATA);

        // Wrap-around for both increments
        wr(PPUADDR, 8'h3F);
        wr(PPUADDR, 8'hFF);
        wr(PPUDATA, 8'h66);
        check("wrap1", {16'd0, vram_addr}, 32'h0000);
        wr(PPUCTRL, 8'h04);
        wr(PPUADDR, 8'h3F);
        wr(PPUADDR, 8'hE0);
        wr(PPUDATA, 8'h67);
        check("wrap32", {16'd0, vram_addr}, 32'h0000);
        wr(PPUCTRL, 8'h00);

        // PPUSTATUS read clears the write toggle
        wr(PPUADDR, 8'h12);
        rd(PPUSTATUS);
        wr(PPUADDR, 8'h05);
        wr(PPUADDR, 8'h40);
        check("v_0540", {16'd0, vram_addr}, 32'h0540);

        // Strobe while busy is dropped (would otherwise flip w)
        wr_q.push_back('{addr: {2'b00, v_m}, data: 8'h99, pal: 1'b0});
        v_m = inc_v(v_m);
        strobe(1'b0, PPUDATA, 8'h99);
        strobe(1'b0, PPUADDR, 8'h3F);
        wait_idle();
        check_v("v_after_drop");
        wr(PPUADDR, 8'h07);
        wr(PPUADDR, 8'h00);
        check("v_0700", {16'd0, vram_addr}, 32'h0700);

        // Reset during WR aborts the access
        wr(PPUADDR, 8'h12);
        wr(PPUADDR, 8'h34);
        wr_q.push_back('{addr: {2'b00, v_m}, data: 8'hC3, pal: 1'b0});
        strobe(1'b0, PPUDATA, 8'hC3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rstwr_vram_we", {31'd0, vram_we}, 32'd0);
        check("rstwr_pal_we", {31'd0, pal_we}, 32'd0);
        check("rstwr_busy", {31'd0, busy}, 32'd0);
        check("rstwr_v", {16'd0, vram_addr}, 32'd0);
        check("rstwr_wdata", {24'd0, vram_wdata}, 32'd0);
        rd(PPUDATA);

        repeat (3) @(posedge clk);
        #1;
        check("wr_q_empty", wr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
